// File: rtl/pic_fetch_ctrl.sv
// Fetch/execute sequencer for the PIC-style core: owns pc, drives the program ROM, holds ir.
// Optional single-step support is built only when PIC_SEQ_STEP_EN is defined.
module pic_fetch_ctrl #(
  parameter int PC_W    = 10,
  parameter int INSN_W  = 12,
  parameter int ROM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              step,
  input  logic              halt_req,
  output logic [PC_W-1:0]   rom_addr,
  output logic              rom_oe,
  input  logic [INSN_W-1:0] rom_data,
  output logic [INSN_W-1:0] ir,
  output logic              ir_valid,
  input  logic              exec_done,
  input  logic              jump_en,
  input  logic [PC_W-1:0]   jump_addr,
  input  logic              skip,
  output logic [PC_W-1:0]   pc,
  output logic              pc_wrap,
  output logic              halted,
  output logic [2:0]        state
);

  localparam int CNT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(ROM_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOAD   = 3'd2,
    S_EXEC   = 3'd3,
    S_UPDATE = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_wait;
  logic [PC_W-1:0]    r_pc;
  logic [INSN_W-1:0]  r_ir;
  logic               r_ir_valid;
  logic               r_rom_oe;
  logic               r_pc_wrap;
  logic               r_halted;
  logic               r_halt;
  logic               r_jmp;
  logic               r_skip;
  logic [PC_W-1:0]    r_jaddr;
  logic [PC_W:0]      w_inc_sum;
  logic               w_step_req;
  logic               w_step_mode;

`ifdef PIC_SEQ_STEP_EN
  logic r_step_mode;

  assign w_step_req  = step;
  assign w_step_mode = r_step_mode;

  // Step mode lives from the IDLE exit until the instruction's UPDATE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step_mode <= 1'b0;
    end else if (r_state == S_IDLE && !run && step) begin
      r_step_mode <= 1'b1;
    end else if (r_state == S_UPDATE) begin
      r_step_mode <= 1'b0;
    end
  end
`else
  logic w_unused_step;

  assign w_unused_step = step;
  assign w_step_req    = 1'b0;
  assign w_step_mode   = 1'b0;
`endif

  assign w_inc_sum = {1'b0, r_pc} + {{(PC_W-1){1'b0}}, r_skip, ~r_skip};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (run || w_step_req) w_next = S_FETCH;
      S_FETCH:  if (r_wait == LAST_WAIT) w_next = S_LOAD;
      S_LOAD:   w_next = S_EXEC;
      S_EXEC:   if (exec_done) w_next = S_UPDATE;
      S_UPDATE: begin
        if (r_halt || halt_req)       w_next = S_HALT;
        else if (w_step_mode || !run) w_next = S_IDLE;
        else                          w_next = S_FETCH;
      end
      S_HALT:   if (!run) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_wait     <= '0;
      r_pc       <= '0;
      r_ir       <= '0;
      r_ir_valid <= 1'b0;
      r_rom_oe   <= 1'b0;
      r_pc_wrap  <= 1'b0;
      r_halted   <= 1'b0;
      r_halt     <= 1'b0;
      r_jmp      <= 1'b0;
      r_skip     <= 1'b0;
      r_jaddr    <= '0;
    end else begin
      r_state    <= w_next;
      r_rom_oe   <= (w_next == S_FETCH) || (w_next == S_LOAD);
      r_ir_valid <= (w_next == S_EXEC);
      r_halted   <= (w_next == S_HALT);

      if (r_state == S_FETCH && r_wait != LAST_WAIT) r_wait <= r_wait + 1'b1;
      else                                           r_wait <= '0;

      if (w_next == S_HALT) r_halt <= 1'b0;
      else if (halt_req && r_state != S_IDLE && r_state != S_HALT) r_halt <= 1'b1;

      if (r_state == S_LOAD) r_ir <= rom_data;

      // Execute-stage controls are captured with exec_done and applied in UPDATE.
      if (r_state == S_EXEC && exec_done) begin
        r_jmp   <= jump_en;
        r_skip  <= skip;
        r_jaddr <= jump_addr;
      end

      r_pc_wrap <= 1'b0;
      if (r_state == S_UPDATE) begin
        if (r_jmp) begin
          r_pc <= r_jaddr;
        end else begin
          r_pc      <= w_inc_sum[PC_W-1:0];
          r_pc_wrap <= w_inc_sum[PC_W];
        end
      end
    end
  end

  assign rom_addr = r_pc;
  assign rom_oe   = r_rom_oe;
  assign ir       = r_ir;
  assign ir_valid = r_ir_valid;
  assign pc       = r_pc;
  assign pc_wrap  = r_pc_wrap;
  assign halted   = r_halted;
  assign state    = r_state;

endmodule
